// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared definitions for the multi-channel clock generator.
//   - ch0_state_e : channel-0 single-step state machine encoding
//   - *_DEFAULT   : default values for the NCH / DW / CW parameters
package clk_gen_pkg;

    localparam int unsigned NCH_DEFAULT = 2;
    localparam int unsigned DW_DEFAULT  = 25;
    localparam int unsigned CW_DEFAULT  = 32;

    typedef enum logic [1:0] {
        StRun,
        StDrain,
        StIdle,
        StStepHi
    } ch0_state_e;

endpackage

// File: rtl/clk_gen_ch.sv
// clk_gen_ch: one divided-clock channel (down-counter, toggle flop, ce generator).
// Ports:
//   clk, rst      - board clock, asynchronous active-high reset
//   div           - half-period value N (half-period is N+1 cycles), sampled at reload only
//   hold          - park: force output low and clear the counter
//   force_reload  - start a high phase now: output high, ce high, counter loaded from div
//   clk_out       - divided clock level (registered)
//   ce            - one-cycle pulse in the first cycle of each high phase
//   last          - counter is zero (the next edge toggles unless overridden)
module clk_gen_ch
    import clk_gen_pkg::*;
#(
    parameter int unsigned DW = DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] div,
    input  logic          hold,
    input  logic          force_reload,
    output logic          clk_out,
    output logic          ce,
    output logic          last
);

    logic [DW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          ce_q, ce_d;

    always_comb begin
        cnt_d = cnt_q;
        lvl_d = lvl_q;
        ce_d  = 1'b0;
        if (hold) begin
            cnt_d = '0;
            lvl_d = 1'b0;
        end else if (force_reload) begin
            cnt_d = div;
            lvl_d = 1'b1;
            ce_d  = 1'b1;
        end else if (cnt_q == '0) begin
            // div is only looked at here, so a phase in progress always
            // finishes at the ratio it started with.
            cnt_d = div;
            lvl_d = ~lvl_q;
            ce_d  = ~lvl_q;
        end else begin
            cnt_d = cnt_q - DW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            lvl_q <= 1'b0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            lvl_q <= lvl_d;
            ce_q  <= ce_d;
        end
    end

    assign clk_out = lvl_q;
    assign ce      = ce_q;
    assign last    = (cnt_q == '0);

endmodule

// File: rtl/clk_gen.sv
// clk_gen: free-running clkdiv counter plus NCH programmable divided clocks.
// Channel 0 can be parked low and single-stepped from a push button.
// Build option: define CLK_GEN_STEP_EN to include the step synchroniser and the
// channel-0 step state machine; without it step_mode/step are ignored and
// cpu_parked is tied low.
// Ports:
//   clk, rst    - board clock, asynchronous active-high reset
//   div         - per-channel half-period, slice i = div[i*DW +: DW]
//   step_mode   - request parking / single-step mode on channel 0
//   step        - debounced step button, asynchronous to clk
//   clkdiv      - free-running up-counter
//   clk_out     - divided clock levels
//   ce          - first-cycle-of-high-phase enables
//   cpu_parked  - channel 0 is parked low awaiting a step
module clk_gen
    import clk_gen_pkg::*;
#(
    parameter int unsigned NCH = NCH_DEFAULT,
    parameter int unsigned DW  = DW_DEFAULT,
    parameter int unsigned CW  = CW_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH*DW-1:0] div,
    input  logic              step_mode,
    input  logic              step,
    output logic [CW-1:0]     clkdiv,
    output logic [NCH-1:0]    clk_out,
    output logic [NCH-1:0]    ce,
    output logic              cpu_parked
);

    logic [CW-1:0]  clkdiv_q;
    logic [NCH-1:0] hold, force_reload, last;
    logic           hold0, force0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clkdiv_q <= '0;
        end else begin
            clkdiv_q <= clkdiv_q + CW'(1);
        end
    end

    assign clkdiv = clkdiv_q;

    // Only channel 0 is ever overridden.
    always_comb begin
        hold            = '0;
        force_reload    = '0;
        hold[0]         = hold0;
        force_reload[0] = force0;
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        clk_gen_ch #(
            .DW(DW)
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .div          (div[g*DW +: DW]),
            .hold         (hold[g]),
            .force_reload (force_reload[g]),
            .clk_out      (clk_out[g]),
            .ce           (ce[g]),
            .last         (last[g])
        );
    end

    logic unused_last;
    assign unused_last = ^last;

`ifdef CLK_GEN_STEP_EN
    logic       step_meta_q, step_sync_q, step_prev_q;
    logic       step_p;
    ch0_state_e state_q, state_d;
    logic       parked_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_meta_q <= 1'b0;
            step_sync_q <= 1'b0;
            step_prev_q <= 1'b0;
        end else begin
            step_meta_q <= step;
            step_sync_q <= step_meta_q;
            step_prev_q <= step_sync_q;
        end
    end

    assign step_p = step_sync_q & ~step_prev_q;

    always_comb begin
        state_d = state_q;
        hold0   = 1'b0;
        force0  = 1'b0;
        unique case (state_q)
            StRun: begin
                if (step_mode) begin
                    if (!clk_out[0]) begin
                        hold0   = 1'b1;
                        state_d = StIdle;
                    end else if (last[0]) begin
                        // High phase ends on this very edge: park directly.
                        state_d = StIdle;
                    end else begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (last[0]) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                hold0 = 1'b1;
                if (!step_mode) begin
                    // Counter left at zero so the clock rises on the next edge.
                    state_d = StRun;
                end else if (step_p) begin
                    hold0   = 1'b0;
                    force0  = 1'b1;
                    state_d = StStepHi;
                end
            end
            StStepHi: begin
                // Normal toggle reloads the counter, giving a full low phase in RUN.
                if (last[0]) begin
                    state_d = step_mode ? StIdle : StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StRun;
            parked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            parked_q <= (state_d == StIdle);
        end
    end

    assign cpu_parked = parked_q;
`else
    logic unused_step;
    assign unused_step = step_mode ^ step;
    assign hold0       = 1'b0;
    assign force0      = 1'b0;
    assign cpu_parked  = 1'b0;
`endif

endmodule

// File: tb/tb_clk_gen.sv
// tb_clk_gen: directed self-checking bench for clk_gen with a phase-length model.
module tb_clk_gen;

    localparam int NCH = 2;
    localparam int DW  = 25;
    localparam int CW  = 8;

`ifdef CLK_GEN_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif

    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_PARK  = 2;
    localparam int M_STEP  = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NCH*DW-1:0] div;
    logic              step_mode;
    logic              step;
    logic [CW-1:0]     clkdiv;
    logic [NCH-1:0]    clk_out;
    logic [NCH-1:0]    ce;
    logic              cpu_parked;

    clk_gen #(
        .NCH(NCH),
        .DW (DW),
        .CW (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .div        (div),
        .step_mode  (step_mode),
        .step       (step),
        .clkdiv     (clkdiv),
        .clk_out    (clk_out),
        .ce         (ce),
        .cpu_parked (cpu_parked)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 'h%0h want 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: each channel tracks level and cycles left in phase
    bit            m_lvl[NCH];
    int            m_left[NCH];
    bit            m_ce[NCH];
    int            m_mode;
    bit            m_parked;
    logic [CW-1:0] m_cd;
    bit            h1, h2, h3, m_sp;

    function automatic int divof(input int i);
        return int'(div[i*DW +: DW]);
    endfunction

    task automatic advance(input int i);
        m_ce[i] = 1'b0;
        m_left[i]--;
        if (m_left[i] == 0) begin
            m_lvl[i]  = !m_lvl[i];
            m_left[i] = divof(i) + 1;
            m_ce[i]   = m_lvl[i];
        end
    endtask

    task automatic ch0_step(input bit sp);
        case (m_mode)
            M_RUN: begin
                if (step_mode) begin
                    if (!m_lvl[0]) begin
                        m_ce[0]   = 1'b0;
                        m_left[0] = 1;
                        m_mode    = M_PARK;
                    end else begin
                        advance(0);
                        m_mode = m_lvl[0] ? M_DRAIN : M_PARK;
                    end
                end else begin
                    advance(0);
                end
            end
            M_DRAIN: begin
                advance(0);
                if (!m_lvl[0]) m_mode = M_PARK;
            end
            M_PARK: begin
                m_ce[0] = 1'b0;
                if (!step_mode) begin
                    m_mode    = M_RUN;
                    m_left[0] = 1;
                end else if (sp) begin
                    m_mode    = M_STEP;
                    m_lvl[0]  = 1'b1;
                    m_ce[0]   = 1'b1;
                    m_left[0] = divof(0) + 1;
                end
            end
            default: begin
                advance(0);
                if (!m_lvl[0]) m_mode = step_mode ? M_PARK : M_RUN;
            end
        endcase
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cd     = '0;
            m_mode   = M_RUN;
            m_parked = 1'b0;
            h1 = 1'b0;
            h2 = 1'b0;
            h3 = 1'b0;
            for (int i = 0; i < NCH; i++) begin
                m_lvl[i]  = 1'b0;
                m_left[i] = 1;
                m_ce[i]   = 1'b0;
            end
        end else begin
            // Pulse seen by the state machine: step high two edges ago, low three ago.
            m_sp = h2 && !h3;
            h3 = h2;
            h2 = h1;
            h1 = step;
            m_cd = m_cd + 1'b1;
            for (int i = 1; i < NCH; i++) advance(i);
            if (STEP_EN) ch0_step(m_sp);
            else advance(0);
            m_parked = STEP_EN && (m_mode == M_PARK);
        end
    end

    // ---------------- per-cycle compare against the model
    logic [NCH-1:0] exp_clk, exp_ce;

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            for (int i = 0; i < NCH; i++) begin
                exp_clk[i] = m_lvl[i];
                exp_ce[i]  = m_ce[i];
            end
            check("clkdiv", 64'(clkdiv), 64'(m_cd));
            check("clk_out", 64'(clk_out), 64'(exp_clk));
            check("ce", 64'(ce), 64'(exp_ce));
            check("cpu_parked", 64'(cpu_parked), 64'(m_parked));
        end
    end

    // ---------------- stimulus helpers; bit k of a pattern = k-th recorded cycle
    logic [31:0] pc0, pc1, pce0, pce1, ppk;
    int          idx;

    task automatic clear_pat();
        pc0 = '0; pc1 = '0; pce0 = '0; pce1 = '0; ppk = '0; idx = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (idx < 32) begin
            pc0[idx]  = clk_out[0];
            pc1[idx]  = clk_out[1];
            pce0[idx] = ce[0];
            pce1[idx] = ce[1];
            ppk[idx]  = cpu_parked;
        end
        idx++;
    endtask

    task automatic wait_ce0();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (ce[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_ce0: got no ce[0] want ce[0] within 200 cycles");
        end
    endtask

    task automatic wait_parked();
        bit ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            tick();
            if (cpu_parked) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL wait_parked: got cpu_parked=0 want 1 within 200 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        div       = {25'd0, 25'd3};
        step_mode = 1'b0;
        step      = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst clkdiv", 64'(clkdiv), 64'd0);
        check("rst clk_out", 64'(clk_out), 64'd0);
        check("rst ce", 64'(ce), 64'd0);
        check("rst cpu_parked", 64'(cpu_parked), 64'd0);
        #10 rst = 1'b0;
        chk_en = 1'b1;

        // Reset release, div = {0,3}
        clear_pat();
        tick();
        check("first edge clkdiv", 64'(clkdiv), 64'd1);
        check("first edge clk_out", 64'(clk_out), 64'd3);
        check("first edge ce", 64'(ce), 64'd3);
        repeat (15) tick();
        check("ch0 div3 pattern", 64'(pc0), 64'h0F0F);
        check("ch1 div0 pattern", 64'(pc1), 64'h5555);
        check("ce0 div3 pattern", 64'(pce0), 64'h0101);
        check("ce1 div0 pattern", 64'(pce1), 64'h5555);

        // Ratio change 3 -> 1 during a high phase
        tick();
        div[0 +: DW] = 25'd1;
        clear_pat();
        repeat (10) tick();
        check("ratio change clk0", 64'(pc0), 64'h267);
        check("ratio change ce0", 64'(pce0), 64'h220);

        // step_mode asserted one cycle into a div=3 high phase
        div[0 +: DW] = 25'd3;
        wait_ce0();
        step_mode = 1'b1;
        clear_pat();
        repeat (6) tick();
        check("drain clk0", 64'(pc0), 64'h07);
`ifdef CLK_GEN_STEP_EN
        check("drain parked", 64'(ppk), 64'h38);
`endif

        // Step press in IDLE with div=2, second press during the high phase
        div[0 +: DW] = 25'd2;
        clear_pat();
        for (int k = 0; k < 12; k++) begin
            step = (k == 0 || k == 1 || k == 3 || k == 4);
            tick();
        end
        step = 1'b0;
`ifdef CLK_GEN_STEP_EN
        check("step clk0", 64'(pc0), 64'h01C);
        check("step ce0", 64'(pce0), 64'h004);
        check("step parked", 64'(ppk), 64'hFE3);
`endif

        // step_mode release coincident with step_p
        clear_pat();
        for (int k = 0; k < 10; k++) begin
            step      = (k <= 2);
            step_mode = (k < 2);
            tick();
        end
        step = 1'b0;
`ifdef CLK_GEN_STEP_EN
        check("resume clk0", 64'(pc0), 64'h238);
        check("resume ce0", 64'(pce0), 64'h208);
        check("resume parked", 64'(ppk), 64'h003);
`endif

        // Reset asserted during a step high phase
        step_mode = 1'b1;
`ifdef CLK_GEN_STEP_EN
        wait_parked();
        step = 1'b1;
        tick();
        tick();
        step = 1'b0;
        tick();
        tick();
        check("pre-reset step high", 64'(clk_out[0]), 64'd1);
`endif
        #2 rst = 1'b1;
        #1;
        check("async rst clkdiv", 64'(clkdiv), 64'd0);
        check("async rst clk_out", 64'(clk_out), 64'd0);
        check("async rst ce", 64'(ce), 64'd0);
        check("async rst cpu_parked", 64'(cpu_parked), 64'd0);
        step_mode = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b0;
        clear_pat();
        tick();
        check("post-reset clk_out", 64'(clk_out), 64'd3);
        check("post-reset ce", 64'(ce), 64'd3);
        check("post-reset clkdiv", 64'(clkdiv), 64'd1);

        // Long run: clkdiv wraps, model keeps checking every cycle
        repeat (300) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/clk_gen.md
# clk_gen

Parametrised multi-channel clock generator, the successor to the fixed two-tap CPU clock divider. It keeps the free-running `clkdiv` counter for display scanning and adds up to `NCH` independent channels with runtime-programmable integer ratios and glitch-free ratio changes. Channel 0 drives the CPU clock and adds a single-step mode: it parks low and emits exactly one full high phase per step-button press. It sits at the top level between the board oscillator/reset and the CPU, display and peripheral clock domains.

## Interface
- `NCH`, 2: number of divided-clock channels (1..8).
- `DW`, 25: width of each channel's half-period value.
- `CW`, 32: width of the free-running `clkdiv` counter.
- `clk`  in  1: board clock; the only clock.
- `rst`  in  1: reset, asynchronous, active-high.
- `div`  in  `NCH*DW`: per-channel half-period; slice i is `div[i*DW +: DW]`; value N gives a half-period of N+1 cycles.
- `step_mode`  in  1: 1 requests step mode on channel 0.
- `step`  in  1: debounced step button level, asynchronous to `clk`.
- `clkdiv`  out  `CW`: free-running up-counter.
- `clk_out`  out  `NCH`: divided clock levels, registered.
- `ce`  out  `NCH`: one-cycle enable; high in the first cycle of each high phase of `clk_out[i]`.
- `cpu_parked`  out  1: channel 0 is in IDLE (step mode, parked low).

## Operation
- `clkdiv`:
  - +1 every cycle; wraps from all-ones to 0.
- Each channel has a down-counter `cnt` of width `DW`.
  - If `cnt`==0: toggle `clk_out`, reload `cnt` from the live `div` slice.
  - Otherwise: decrement `cnt`.
  - Period is 2*(N+1) cycles at 50% duty. N=0 gives clk/2.
- Ratio change:
  - `div` is sampled only at reload, so the half-period in progress always completes at the old value.
  - No runt pulses, no glitches.
- `ce[i]` goes high together with a 0→1 toggle of `clk_out[i]`, for exactly one cycle.
- Step input:
  - Passes through a 2-flop synchroniser, then a rising-edge detector, producing `step_p`.
- Channel 0 state machine (RUN, DRAIN, IDLE, STEP_HI):
  - RUN: normal divide.
    - `step_mode`=1 while `clk_out` low → IDLE; `clk_out` stays low, `cnt` cleared.
    - `step_mode`=1 while `clk_out` high → DRAIN.
  - DRAIN: counts normally. At the high→low toggle → IDLE. The high phase is never shortened.
  - IDLE: `clk_out`=0, `cpu_parked`=1.
    - `step_mode`=0 → RUN with `cnt`=0, so the clock rises on the next edge.
    - Otherwise, `step_p` → STEP_HI with `clk_out`=1, `ce[0]`=1, `cnt`=N.
    - If `step_mode`=0 and `step_p` arrive in the same cycle, `step_mode` wins and `step_p` is discarded.
  - STEP_HI: counts down. At `cnt`==0, `clk_out`→0.
    - Next state is IDLE if `step_mode`=1.
    - Next state is RUN with `cnt`=N if `step_mode`=0, so the low phase is full length.
    - `step_p` pulses during STEP_HI are dropped, not queued.
- Channels 1..NCH-1 ignore `step_mode` and `step`.

## Timing
- Reset values:
  - `clkdiv`=0, `clk_out`=0, `ce`=0, `cpu_parked`=0.
  - All `cnt`=0, state RUN, synchroniser flops 0.
- Reset is asynchronous and may be asserted mid-phase; all of the above apply immediately.
- First rising edge after reset release:
  - `clk_out`=all-ones and `ce`=all-ones.
  - The first high phase lasts N+1 cycles.
- Step latency: `clk_out[0]` goes high on the 3rd `clk` edge after `step` is first sampled high. It stays high exactly N+1 cycles.
- `cpu_parked` is registered and asserts in the same cycle that IDLE is entered.

## Configuration
- `CLK_GEN_STEP_EN`:
  - Defined: synchroniser, edge detector and channel-0 state machine are present as described.
  - Undefined: `step_mode` and `step` are ignored, `cpu_parked` is tied 0, and channel 0 behaves like the other channels.

## Structure
- Package `clk_gen_pkg` holds:
  - the channel-0 state enum (RUN, DRAIN, IDLE, STEP_HI);
  - default constants for `NCH`, `DW`, `CW`.
- Sub-module `clk_gen_ch`:
  - one counter, toggle flop and `ce` generator;
  - instantiated `NCH` times in a generate loop;
  - takes a `hold`/`force_reload` control from the channel-0 state machine in the top.

## Test plan
- Reset release, `NCH`=2, div={3,0} → ch1 toggles every cycle; ch0 has period 8 (4 high/4 low); `ce` pulses every 8 and every 2 cycles.
- Change ch0 div from 3 to 1 mid-high-phase → the current high phase still lasts 4 cycles, then the period becomes 4; no runt pulses.
- `step_mode`=1 asserted 1 cycle into a ch0 high phase (div=3) → 3 more high cycles (DRAIN), then IDLE with `cpu_parked`=1.
- In IDLE with div=2, pulse `step` → `clk_out[0]` rises on the 3rd edge, stays high 3 cycles, returns to IDLE; a second press during the high phase produces nothing.
- `step_mode` 1→0 coincident with `step_p` → no step pulse; RUN resumes and `clk_out[0]` rises next edge; ch1 undisturbed throughout.
- Assert `rst` mid-STEP_HI → all outputs 0 immediately; after release both channels rise on the first edge.
